srrc_fold_ctrl: RTL and testbench



---
 rtl/srrc_fold_ctrl_pkg.sv | 18 +
 rtl/srrc_fold_ctrl_mac.sv | 38 +++
 rtl/srrc_fold_ctrl.sv | 106 ++++++++++
 tb/tb_srrc_fold_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/srrc_fold_ctrl_pkg.sv
// Shared definitions for the SRRC filter family: widths, FSM states and
// the default 9-entry unique coefficient set of the 17-tap symmetric filter.
package srrc_pkg;

    localparam int DW    = 18;
    localparam int NTAPS = 17;
    localparam int NUNIQ = (NTAPS + 1) / 2;

    typedef enum logic {IDLE, RUN} state_t;

    typedef logic signed [DW-1:0] sample_t;

    localparam sample_t DEFAULT_COEF [NUNIQ] = '{
        18'sd3259,  -18'sd3378, -18'sd10461, -18'sd12207, -18'sd3946,
        18'sd14611, 18'sd38196, 18'sd57937,  18'sd65624
    };

endpackage

// File: rtl/srrc_fold_ctrl_mac.sv
// Shared pre-add / multiply / accumulate datapath for the folded filter.
// acc presents the running sum with the current term already folded in, so
// the controller can capture the finished result on the last step's edge.
module srrc_fold_mac
    import srrc_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    clear,
    input  logic    enable,
    input  logic    mid,
    input  sample_t tap_lo,
    input  sample_t tap_hi,
    input  sample_t coef,
    output sample_t acc
);

    sample_t                sum_q;
    sample_t                pre;
    logic signed [2*DW-1:0] prod;

    // Pre-add mirrored taps (centre tap passes alone), multiply, keep [34:17]
    always_comb begin
        pre  = mid ? tap_lo : sample_t'(tap_lo + tap_hi);
        prod = (2*DW)'(pre) * (2*DW)'(coef);
        acc  = sum_q + sample_t'(prod[2*DW-2:DW-1]);
    end

    // Wrapping accumulator register, cleared when a new sample is accepted
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum_q <= '0;
        end else if (enable) begin
            sum_q <= acc;
        end
    end

endmodule

// File: rtl/srrc_fold_ctrl.sv
// Sequencer for a folded 17-tap symmetric SRRC filter: sample handshake,
// delay line, tap/coefficient sequencing and a double-buffered coef bank.
module srrc_fold_ctrl
    import srrc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] out,
    output logic                 out_valid,
    input  logic                 coef_we,
    input  logic [3:0]           coef_addr,
    input  logic signed [DW-1:0] coef_data,
    input  logic                 coef_commit,
    output logic                 commit_pending
);

    state_t     state;
    logic [3:0] cnt;
    sample_t    x      [NTAPS];
    sample_t    shadow [NUNIQ];
    sample_t    active [NUNIQ];
    sample_t    acc;
    logic       accept;
    logic       apply_commit;
    logic       last;
    logic       run;
    logic [4:0] lo_idx;
    logic [4:0] hi_idx;

    assign in_ready     = (state == IDLE);
    assign run          = (state == RUN);
    assign accept       = in_ready && in_valid;
    // A commit is applied on any IDLE edge, so the active bank is frozen while running
    assign apply_commit = in_ready && (commit_pending || coef_commit);
    assign last         = (cnt == 4'(NUNIQ - 1));
    assign lo_idx       = 5'(cnt);
    assign hi_idx       = 5'(NTAPS - 1) - 5'(cnt);

    srrc_fold_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (run),
        .mid    (last),
        .tap_lo (x[lo_idx]),
        .tap_hi (x[hi_idx]),
        .coef   (active[cnt]),
        .acc    (acc)
    );

    // FSM, delay line, coefficient banks and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            x              <= '{default: '0};
            out            <= '0;
            out_valid      <= 1'b0;
            commit_pending <= 1'b0;
            shadow         <= DEFAULT_COEF;
            active         <= DEFAULT_COEF;
        end else begin
            out_valid <= 1'b0;

            if (coef_we && (coef_addr < 4'(NUNIQ))) begin
                shadow[coef_addr] <= coef_data;
            end

            // active takes the pre-write shadow when a write and commit coincide
            if (apply_commit) begin
                active         <= shadow;
                commit_pending <= 1'b0;
            end else if (coef_commit) begin
                commit_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = NTAPS - 1; i > 0; i--) begin
                            x[i] <= x[i - 1];
                        end
                        x[0]  <= in;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (last) begin
                        out       <= acc;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_srrc_fold_ctrl.sv
// Self-checking bench for srrc_fold_ctrl: a transaction-level filter model
// compared every cycle, plus directed scenarios with hand-computed results.
module tb_srrc_fold_ctrl;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [17:0] in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [17:0] out;
    logic               out_valid;
    logic               coef_we = 1'b0;
    logic [3:0]         coef_addr = '0;
    logic signed [17:0] coef_data = '0;
    logic               coef_commit = 1'b0;
    logic               commit_pending;

    always #5 clk = ~clk;

    srrc_fold_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .in             (in),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out            (out),
        .out_valid      (out_valid),
        .coef_we        (coef_we),
        .coef_addr      (coef_addr),
        .coef_data      (coef_data),
        .coef_commit    (coef_commit),
        .commit_pending (commit_pending)
    );

    int     n_checks = 0;
    int     n_fail = 0;
    longint cyc = 0;

    longint m_def [9] = '{3259, -3378, -10461, -12207, -3946, 14611, 38196, 57937, 65624};
    longint m_hist [17];
    longint m_shadow [9];
    longint m_active [9];
    longint m_old [9];
    longint m_res = 0;
    longint m_out = 0;
    bit     m_valid = 0;
    bit     m_pend = 0;
    int     m_busy = 0;
    bit     m_live = 0;
    bit     m_idle;
    longint acc_q [$];
    longint got_q [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint wrap18(input longint v);
        logic signed [17:0] t;
        t = v[17:0];
        return longint'(t);
    endfunction

    // y = sum_k floor(pre_k * c_k / 2^17), every add wrapped to 18 bits
    function automatic longint model_filter();
        longint a = 0;
        longint pre;
        for (int k = 0; k < 9; k++) begin
            pre = (k == 8) ? m_hist[8] : wrap18(m_hist[k] + m_hist[16 - k]);
            a   = wrap18(a + wrap18((pre * m_active[k]) >>> 17));
        end
        return a;
    endfunction

    // Reference model: advances on every clock edge from the applied inputs
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_hist   = '{default: 0};
            m_shadow = m_def;
            m_active = m_def;
            m_pend   = 0;
            m_busy   = 0;
            m_out    = 0;
            m_valid  = 0;
            m_live   = 1;
            acc_q.delete();
        end else begin
            m_valid = 0;
            m_idle  = (m_busy == 0);
            m_old   = m_shadow;
            if (coef_we && coef_addr < 9) m_shadow[coef_addr] = longint'(coef_data);
            if (m_idle && (m_pend || coef_commit)) begin
                m_active = m_old;
                m_pend   = 0;
            end else if (coef_commit) begin
                m_pend = 1;
            end
            if (m_idle && in_valid) begin
                for (int i = 16; i > 0; i--) m_hist[i] = m_hist[i - 1];
                m_hist[0] = longint'(in);
                m_res  = model_filter();
                m_busy = 9;
                acc_q.push_back(cyc - 1);
            end else if (!m_idle) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid = 1;
                    m_out   = m_res;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready", longint'(in_ready), longint'(m_busy == 0));
            check("out_valid", longint'(out_valid), longint'(m_valid));
            check("out", longint'(out), m_out);
            check("commit_pending", longint'(commit_pending), longint'(m_pend));
            if (out_valid) begin
                got_q.push_back(longint'(out));
                if (acc_q.size() > 0) check("latency", cyc - acc_q.pop_front(), 10);
                else check("latency_orphan", 1, 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic send(input logic signed [17:0] s);
        int t = 0;
        in = s;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", longint'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int t = 0;
        while (got_q.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("out_count", got_q.size(), n);
    endtask

    longint imp [18] = '{1629, -1689, -5231, -6104, -1973, 7305, 19098, 28968, 32812,
                         28968, 19098, 7305, -1973, -6104, -5231, -1689, 1629, 0};
    longint bp_log [$];
    bit     took;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Impulse through default coefficients
        got_q.delete();
        send(18'sd65536);
        repeat (17) send(18'sd0);
        wait_outs(18);
        for (int i = 0; i < 18; i++) check("impulse", got_q[i], imp[i]);

        // Backpressure: in_valid held high, data advances only on accept
        do_reset();
        bp_log.delete();
        took = 0;
        in = 18'($urandom);
        in_valid = 1'b1;
        repeat (62) begin
            @(negedge clk);
            if (took) in = 18'($urandom);
            took = in_ready;
            if (in_ready) bp_log.push_back(cyc);
        end
        in_valid = 1'b0;
        check("bp_accepts", longint'(bp_log.size() >= 6), 1);
        for (int i = 1; i < bp_log.size(); i++) check("bp_gap", bp_log[i] - bp_log[i - 1], 10);

        // Coefficient swap written and committed mid-RUN
        do_reset();
        send(18'sd65536);
        for (int k = 0; k < 9; k++) begin
            coef_we = 1'b1;
            coef_addr = 4'(k);
            coef_data = (k == 0) ? 18'sd65536 : 18'sd0;
            coef_commit = (k == 4);
            @(negedge clk);
        end
        coef_we = 1'b0;
        coef_commit = 1'b0;
        check("swap_pending_held", longint'(commit_pending), 1);
        wait_outs(1);
        check("swap_inflight", got_q[0], 1629);
        @(negedge clk);
        check("swap_pending_clear", longint'(commit_pending), 0);
        send(18'sd65536);
        wait_outs(2);
        check("swap_new_bank", got_q[1], 32768);

        // Write and commit in the same IDLE cycle
        do_reset();
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 18'sd100; coef_commit = 1'b1;
        @(negedge clk);
        coef_we = 1'b0; coef_commit = 1'b0;
        check("coll_pending", longint'(commit_pending), 0);
        send(18'sd65536);
        wait_outs(1);
        check("coll_old_bank", got_q[0], 1629);
        coef_commit = 1'b1;
        @(negedge clk);
        coef_commit = 1'b0;
        send(18'sd65536);
        wait_outs(2);
        check("coll_second_commit", got_q[1], -1639);

        // Reset asserted while cnt==4
        do_reset();
        send(18'sd65536);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out", longint'(out), 0);
        repeat (15) @(negedge clk);
        check("rst_no_output", got_q.size(), 0);
        send(18'sd65536);
        wait_outs(1);
        check("rst_impulse", got_q[0], 1629);

        // Full-scale input: pre-adds wrap, accumulation wraps without saturation
        do_reset();
        repeat (17) send(18'sd131071);
        wait_outs(17);
        check("wrap_full", got_q[16], 65619);

        // Randomized traffic, coefficient updates, commits and resets
        do_reset();
        repeat (900) begin
            @(negedge clk);
            in_valid    = ($urandom_range(0, 1) == 1);
            in          = 18'($urandom);
            coef_we     = ($urandom_range(0, 7) == 0);
            coef_addr   = 4'($urandom);
            coef_data   = 18'($urandom);
            coef_commit = ($urandom_range(0, 15) == 0);
            reset       = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0; reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
